// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light monitor: lamp phases, error codes and
// the legal phase successor.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_TRACK    = 1'b1
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_RED:       n = PH_RED_AMBER;
            PH_RED_AMBER: n = PH_GREEN;
            PH_GREEN:     n = PH_AMBER;
            default:      n = PH_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_pattern_decode.sv
// Combinational decode of the {red,amber,green} lamp pattern into a phase
// plus a legality flag.
module tl_pattern_decode
    import traffic_pkg::*;
(
    input  logic [2:0] pattern,
    output logic       legal,
    output logic [1:0] phase
);

    always_comb begin
        legal = 1'b1;
        phase = PH_RED;
        case (pattern)
            3'b100:  phase = PH_RED;
            3'b110:  phase = PH_RED_AMBER;
            3'b001:  phase = PH_GREEN;
            3'b010:  phase = PH_AMBER;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// In-system checker for the traffic-light controller: locks onto the lamp
// phase, tracks order and dwell, captures the first error, counts sequences.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             amber,
    input  logic             green,
    input  logic             clr_err,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] seq_count
);

    localparam int DW = $clog2(MAX_DWELL + 1);
    localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

    state_t        state;
    phase_t        cur;
    logic [DW-1:0] dwell;

    logic          dec_legal;
    logic [1:0]    dec_raw;
    phase_t        dec_ph;
    logic          is_next;
    logic          new_err;
    logic [2:0]    new_code;

    tl_pattern_decode u_decode (
        .pattern ({red, amber, green}),
        .legal   (dec_legal),
        .phase   (dec_raw)
    );

    assign dec_ph  = phase_t'(dec_raw);
    assign is_next = (dec_ph == next_phase(cur));

    // Error classification in priority order; only meaningful while tracking.
    always_comb begin
        new_err  = 1'b0;
        new_code = ERR_NONE;
        if (state == ST_TRACK) begin
            if (!dec_legal) begin
                new_err  = 1'b1;
                new_code = ERR_ILLEGAL;
            end else if (dec_ph != cur && !is_next) begin
                new_err  = 1'b1;
                new_code = ERR_ORDER;
            end else if (is_next && dwell < MIN_D) begin
                new_err  = 1'b1;
                new_code = ERR_SHORT;
            end else if (dec_ph == cur && dwell == MAX_D) begin
                new_err  = 1'b1;
                new_code = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_UNLOCKED;
            cur       <= PH_RED;
            dwell     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            seq_count <= '0;
        end else begin
            // A new error beats a simultaneous clear; otherwise keep the first code.
            if (new_err) begin
                err <= 1'b1;
                if (!err || clr_err) err_code <= new_code;
            end else if (clr_err) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end

            case (state)
                ST_UNLOCKED: begin
                    if (dec_legal) begin
                        state <= ST_TRACK;
                        cur   <= dec_ph;
                        dwell <= DW'(1);
                    end
                end
                default: begin
                    if (!dec_legal) begin
                        state <= ST_UNLOCKED;
                        dwell <= '0;
                    end else if (dec_ph != cur) begin
                        // Covers both advance and ORDER re-lock; only a true
                        // AMBER->RED advance completes a sequence.
                        cur   <= dec_ph;
                        dwell <= DW'(1);
                        if (is_next && cur == PH_AMBER && seq_count != '1)
                            seq_count <= seq_count + CNT_W'(1);
                    end else if (dwell == MAX_D) begin
                        dwell <= DW'(1);
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
            endcase
        end
    end

    assign locked = (state == ST_TRACK);
    assign phase  = cur;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized and directed bench for traffic_light_monitor: two instances
// (default dwell limits, and MIN_DWELL=2 with a 2-bit counter) share stimulus.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red = 1'b0, amber = 1'b0, green = 1'b0, clr_err = 1'b0;

    logic       locked_a, err_a;
    logic [1:0] phase_a;
    logic [2:0] code_a;
    logic [7:0] seq_a;

    logic       locked_b, err_b;
    logic [1:0] phase_b;
    logic [2:0] code_b;
    logic [1:0] seq_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int locked;
        int ph;
        int dwell;
        int err;
        int code;
        int seq;
        int min_d;
        int max_d;
        int seq_max;
    } mdl_t;

    mdl_t ma, mb;

    // Phase for each {red,amber,green} value; -1 marks an illegal pattern.
    int dec_tab[8] = '{-1, 2, 3, -1, 0, -1, 1, -1};
    logic [2:0] legal_pat[4] = '{3'b100, 3'b110, 3'b001, 3'b010};

    logic [14:0] exp_a_q[$];
    logic [14:0] exp_b_q[$];

    traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
        .clr_err(clr_err), .locked(locked_a), .phase(phase_a), .err(err_a),
        .err_code(code_a), .seq_count(seq_a)
    );

    traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
        .clr_err(clr_err), .locked(locked_b), .phase(phase_b), .err(err_b),
        .err_code(code_b), .seq_count(seq_b)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t model_reset(input mdl_t m);
        mdl_t r = m;
        r.locked = 0; r.ph = 0; r.dwell = 0; r.err = 0; r.code = 0; r.seq = 0;
        return r;
    endfunction

    // Behavioural reference: phases as integers 0..3, successor is (p+1) mod 4.
    function automatic mdl_t model_step(input mdl_t m, input logic [2:0] pat, input logic clr);
        mdl_t r = m;
        int p = dec_tab[pat];
        int e = 0;
        if (m.locked == 0) begin
            if (p >= 0) begin r.locked = 1; r.ph = p; r.dwell = 1; end
        end else if (p < 0) begin
            e = 1; r.locked = 0;
        end else if (p == (m.ph + 1) % 4) begin
            if (m.dwell < m.min_d) e = 3;
            if (m.ph == 3 && m.seq < m.seq_max) r.seq = m.seq + 1;
            r.ph = p; r.dwell = 1;
        end else if (p != m.ph) begin
            e = 2; r.ph = p; r.dwell = 1;
        end else if (m.dwell == m.max_d) begin
            e = 4; r.dwell = 1;
        end else begin
            r.dwell = m.dwell + 1;
        end
        if (e != 0) begin
            if (m.err == 0 || clr) r.code = e;
            r.err = 1;
        end else if (clr) begin
            r.err = 0; r.code = 0;
        end
        return r;
    endfunction

    function automatic logic [14:0] pack_exp(input mdl_t m);
        return {1'(m.locked), 2'(m.ph), 1'(m.err), 3'(m.code), 8'(m.seq)};
    endfunction

    // Scoreboard compare for one instance; phase only matters while locked.
    task automatic compare(input string who, input logic [14:0] e, input int lk,
                           input int ph, input int er, input int cd, input int sq);
        check_val({who, ".locked"}, lk, int'(e[14]));
        if (e[14]) check_val({who, ".phase"}, ph, int'(e[13:12]));
        check_val({who, ".err"}, er, int'(e[11]));
        check_val({who, ".err_code"}, cd, int'(e[10:8]));
        check_val({who, ".seq_count"}, sq, int'(e[7:0]));
    endtask

    // Driver: apply one pattern for one edge, then score both instances.
    task automatic apply(input logic [2:0] pat, input logic clr);
        logic [14:0] ea, eb;
        {red, amber, green} = pat;
        clr_err = clr;
        @(posedge clk);
        ma = model_step(ma, pat, clr);
        mb = model_step(mb, pat, clr);
        exp_a_q.push_back(pack_exp(ma));
        exp_b_q.push_back(pack_exp(mb));
        @(negedge clk);
        clr_err = 1'b0;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        compare("a", ea, int'(locked_a), int'(phase_a), int'(err_a), int'(code_a), int'(seq_a));
        compare("b", eb, int'(locked_b), int'(phase_b), int'(err_b), int'(code_b), int'(seq_b));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic reset_async();
        #1 rst = 1'b1;
        #1;
        check_val("rst.locked", int'(locked_a) + int'(locked_b), 0);
        check_val("rst.phase", int'(phase_a) + int'(phase_b), 0);
        check_val("rst.err", int'(err_a) + int'(err_b), 0);
        check_val("rst.err_code", int'(code_a) + int'(code_b), 0);
        check_val("rst.seq_count", int'(seq_a) + int'(seq_b), 0);
        ma = model_reset(ma);
        mb = model_reset(mb);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seqs(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) apply(legal_pat[k], 1'b0);
    endtask

    initial begin
        logic [2:0] rp;
        int ctrl_ph;
        ma = '{0, 0, 0, 0, 0, 0, 1, 4, 255};
        mb = '{0, 0, 0, 0, 0, 0, 2, 4, 3};

        @(negedge clk);
        reset_async();

        // Legal sequence: phases 0,1,2,3,0 and one completed sequence.
        run_seqs(1);
        apply(3'b100, 1'b0);
        check_val("legal.seq_a", int'(seq_a), 1);
        check_val("legal.err_a", int'(err_a), 0);
        check_val("short.code_b", int'(code_b), 3);

        // Illegal pattern from GREEN, then re-lock in RED.
        apply(3'b110, 1'b0);
        apply(3'b001, 1'b0);
        apply(3'b101, 1'b0);
        check_val("illegal.code_a", int'(code_a), 1);
        apply(3'b100, 1'b0);

        // Order error RED -> GREEN, then a clean advance to AMBER.
        @(negedge clk); reset_async();
        apply(3'b100, 1'b0);
        apply(3'b001, 1'b0);
        check_val("order.code_a", int'(code_a), 2);
        apply(3'b010, 1'b0);

        // Timeout: GREEN held for 5 edges; then clr_err alone; then clr with error.
        @(negedge clk); reset_async();
        apply(3'b100, 1'b0);
        apply(3'b110, 1'b0);
        for (int i = 0; i < 5; i++) apply(3'b001, 1'b0);
        check_val("timeout.code_a", int'(code_a), 4);
        apply(3'b001, 1'b1);
        check_val("clr.err_a", int'(err_a), 0);
        apply(3'b011, 1'b1);
        check_val("clr_vs_err.code_a", int'(code_a), 1);

        // Reset during AMBER with seq_count = 3, then re-lock.
        @(negedge clk); reset_async();
        run_seqs(3);
        apply(3'b100, 1'b0);
        apply(3'b110, 1'b0);
        apply(3'b001, 1'b0);
        apply(3'b010, 1'b0);
        check_val("midrun.seq_a", int'(seq_a), 3);
        reset_async();
        apply(3'b100, 1'b0);

        // Randomized controller with holds, skips, glitches and clears.
        ctrl_ph = 0;
        for (int i = 0; i < 800; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 50) ctrl_ph = (ctrl_ph + 1) % 4;
            else if (r < 88) ctrl_ph = ctrl_ph;
            else if (r < 95) ctrl_ph = $urandom_range(0, 3);
            rp = legal_pat[ctrl_ph];
            if (r >= 95) rp = 3'($urandom_range(0, 7));
            apply(rp, ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 299) == 0) reset_async();
        end

        // Counter saturation on both widths.
        @(negedge clk); reset_async();
        run_seqs(260);
        apply(3'b100, 1'b0);
        check_val("sat.seq_a", int'(seq_a), 255);
        check_val("sat.seq_b", int'(seq_b), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
